// File: rtl/light_pkg.sv
// Shared constants for the light step controller: mode encodings, step codes and input bit indices.
package light_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'b00;
  localparam mode_t MODE_MANUAL = 2'b01;
  localparam mode_t MODE_AUTO   = 2'b10;
  localparam mode_t MODE_PAUSE  = 2'b11;

  localparam int NUM_BTN  = 2;
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int SW_EN    = 0;
  localparam int SW_AUTO  = 1;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_UP   = 2'b01;
  localparam logic [1:0] STEP_DOWN = 2'b10;
endpackage

// File: rtl/button_debounce.sv
// One panel button: 2-FF synchroniser, stable-count debouncer and rising-edge press detect.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          deb, deb_q;
  logic [CW-1:0] cnt;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], i_raw};
      deb_q <= deb;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_level = deb;
  assign o_press = deb & ~deb_q;
endmodule

// File: rtl/light_step_controller.sv
// Front-end sequencer: turns raw switches/buttons into clean 1-cycle step pulses for the light FSM.
module light_step_controller
  import light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_OnOffSW,
  input  logic [1:0] i_button,
  output logic [1:0] o_button,
  output logic [1:0] o_mode
);
  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);

  logic [1:0]         sw_meta, sw_sync;
  logic [NUM_BTN-1:0] press, unused_level;
  mode_t              mode, mode_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [1:0]         step_nxt;
  logic               wrap;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_BTN-1:0] (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_raw    (i_button),
    .o_level  (unused_level),
    .o_press  (press)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      mode     <= MODE_OFF;
      timer    <= '0;
      o_button <= STEP_NONE;
    end else begin
      sw_meta  <= i_OnOffSW;
      sw_sync  <= sw_meta;
      mode     <= mode_nxt;
      timer    <= timer_nxt;
      o_button <= step_nxt;
    end
  end

  // Switch rules outrank button rules.
  always_comb begin
    mode_nxt = mode;
    if (!sw_sync[SW_EN]) begin
      mode_nxt = MODE_OFF;
    end else begin
      case (mode)
        MODE_OFF:    mode_nxt = sw_sync[SW_AUTO] ? MODE_AUTO : MODE_MANUAL;
        MODE_MANUAL: if (sw_sync[SW_AUTO]) mode_nxt = MODE_AUTO;
        MODE_AUTO: begin
          if (!sw_sync[SW_AUTO])   mode_nxt = MODE_MANUAL;
          else if (press[BTN_UP])  mode_nxt = MODE_PAUSE;
        end
        default: begin
          if (!sw_sync[SW_AUTO])   mode_nxt = MODE_MANUAL;
          else if (press[BTN_UP])  mode_nxt = MODE_AUTO;
        end
      endcase
    end
  end

  // Timer runs in AUTO, freezes in PAUSE and idles at zero otherwise; transition cycles never step.
  always_comb begin
    step_nxt  = STEP_NONE;
    timer_nxt = '0;
    wrap      = (timer == TMR_LAST);
    case (mode)
      MODE_MANUAL: begin
        if (press[BTN_UP])        step_nxt = STEP_UP;
        else if (press[BTN_DOWN]) step_nxt = STEP_DOWN;
      end
      MODE_AUTO: begin
        timer_nxt = wrap ? '0 : timer + 1'b1;
        if (wrap) step_nxt = STEP_UP;
      end
      MODE_PAUSE: begin
        timer_nxt = timer;
        if (press[BTN_DOWN]) step_nxt = STEP_UP;
      end
      default: ;
    endcase
    if (mode_nxt != mode) step_nxt = STEP_NONE;
  end

  assign o_mode = mode;
endmodule
